// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard unit: forwarding selects, memory-wait states,
// and the register-hit test used by both forwarding and load-use detection.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } mem_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A writer hits a source only when it really writes a non-x0 register.
    function automatic logic reg_hit(input logic       wr,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
        return wr && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_sel.sv
// Forwarding select for one E-stage ALU operand; the M stage beats the W stage
// because it holds the younger result.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_hit(reg_write_m, rd_m, rs_e)) begin
            sel = FWD_MEM;
        end else if (reg_hit(reg_write_w, rd_w, rs_e)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, load-use/branch stall-flush control and data-memory wait FSM with timeout.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    mem_state_t       state_q;
    logic [WaitW-1:0] waitcnt_q;
    fwd_sel_t         fwd_a;
    fwd_sel_t         fwd_b;
    logic             lw_stall;
    logic             mem_stall;

    forward_sel u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a)
    );

    forward_sel u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b)
    );

    assign lw_stall  = ResultSrcE0 && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = (state_q != RUN) || (dmem_req_M && !dmem_ready);

    // While reset is held, flush D/E so un-reset pipeline registers fill with bubbles.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                // Whole pipeline frozen; a pending redirect waits since E holds PCSrcE.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                StallW = 1'b1;
            end else begin
                StallF = lw_stall && !PCSrcE;
                StallD = lw_stall && !PCSrcE;
                FlushD = PCSrcE;
                FlushE = lw_stall || PCSrcE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            waitcnt_q   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (dmem_req_M && !dmem_ready) begin
                        state_q   <= MEM_WAIT;
                        waitcnt_q <= WaitW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_q   <= RUN;
                        waitcnt_q <= '0;
                    end else if (waitcnt_q == WaitW'(MEM_TIMEOUT)) begin
                        state_q     <= ERROR;
                        mem_timeout <= 1'b1;
                    end else begin
                        waitcnt_q <= waitcnt_q + WaitW'(1);
                    end
                end
                ERROR: begin
                    state_q <= ERROR;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q != ERROR) && ((lw_stall && !PCSrcE) || mem_stall)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (FlushD) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, multi-cycle memory-wait,
// timeout and reset sequences, then randomized traffic against a behavioural model.
module tb_hazard_unit;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, dmem_req_M, dmem_ready;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: how many memory-wait cycles have elapsed, whether frozen for good, counters.
    bit            m_waiting, m_err;
    int            m_wait_cycles;
    logic [CW-1:0] m_stall, m_flush;
    logic [1:0]    e_fa, e_fb;
    bit            e_sfd, e_sall, e_fd, e_fe;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       ld, br;
        logic [4:0] rdm;
        logic       wm;
        logic [4:0] rdw;
        logic       ww;
        logic [1:0] fa, fb;
        logic       sfd, fd, fe;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input int rs1d, input int rs2d, input int rs1e, input int rs2e,
                                input int rde, input int ld, input int br, input int rdm,
                                input int wm, input int rdw, input int ww, input int fa,
                                input int fb, input int sfd, input int fd, input int fe);
        vec_t v;
        v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
        v.rde = 5'(rde); v.ld = 1'(ld); v.br = 1'(br); v.rdm = 5'(rdm); v.wm = 1'(wm);
        v.rdw = 5'(rdw); v.ww = 1'(ww); v.fa = 2'(fa); v.fb = 2'(fb);
        v.sfd = 1'(sfd); v.fd = 1'(fd); v.fe = 1'(fe);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_err = 0; m_wait_cycles = 0; m_stall = '0; m_flush = '0;
    endtask

    task automatic predict();
        bit lw, frozen;
        if (!rst_n) model_reset();
        lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        frozen = m_err || m_waiting || (dmem_req_M && !dmem_ready);
        if (!rst_n) begin
            e_fa = 0; e_fb = 0; e_sfd = 0; e_sall = 0; e_fd = 1; e_fe = 1;
        end else begin
            e_fa = ref_fwd(Rs1E);
            e_fb = ref_fwd(Rs2E);
            if (frozen) begin
                e_sfd = 1; e_sall = 1; e_fd = 0; e_fe = 0;
            end else begin
                e_sfd = lw && !PCSrcE; e_sall = 0; e_fd = PCSrcE; e_fe = lw || PCSrcE;
            end
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_err && e_sfd) m_stall = m_stall + 1;
        if (e_fd) m_flush = m_flush + 1;
        if (m_err) begin
        end else if (m_waiting) begin
            if (dmem_ready) begin
                m_waiting = 0; m_wait_cycles = 0;
            end else if (m_wait_cycles == TO) begin
                m_err = 1;
            end else begin
                m_wait_cycles++;
            end
        end else if (dmem_req_M && !dmem_ready) begin
            m_waiting = 1; m_wait_cycles = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".FwdA"}, ForwardAE, e_fa);
        chk({tag, ".FwdB"}, ForwardBE, e_fb);
        chk({tag, ".StallF"}, StallF, e_sfd);
        chk({tag, ".StallD"}, StallD, e_sfd);
        chk({tag, ".StallE"}, StallE, e_sall);
        chk({tag, ".StallM"}, StallM, e_sall);
        chk({tag, ".StallW"}, StallW, e_sall);
        chk({tag, ".FlushD"}, FlushD, e_fd);
        chk({tag, ".FlushE"}, FlushE, e_fe);
        chk({tag, ".timeout"}, mem_timeout, m_err);
        chk({tag, ".stall_cnt"}, stall_cnt, PERF ? m_stall : '0);
        chk({tag, ".flush_cnt"}, flush_cnt, PERF ? m_flush : '0);
    endtask

    // Inputs are already driven; check mid-cycle, then advance one clock.
    task automatic step(input string tag);
        #1;
        predict();
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        dmem_req_M = 0; dmem_ready = 1;
    endtask

    initial begin
        int n;
        tbl[0]  = mk(1, 2, 5, 0, 0, 0, 0, 5, 1, 5, 1, 2, 0, 0, 0, 0);
        tbl[1]  = mk(1, 2, 5, 0, 0, 0, 0, 5, 0, 5, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 2, 3, 9, 0, 0, 0, 3, 1, 9, 1, 2, 1, 0, 0, 0);
        tbl[4]  = mk(1, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(7, 3, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[7]  = mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[8]  = mk(7, 3, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 2, 6, 6, 0, 0, 0, 5, 1, 6, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 2, 4, 4, 0, 0, 0, 4, 1, 4, 1, 2, 2, 0, 0, 0);

        idle();
        model_reset();
        #1 rst_n = 0;
        step("reset0");
        step("reset1");
        rst_n = 1;
        step("idle");

        foreach (tbl[i]) begin
            Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
            RdE = tbl[i].rde; ResultSrcE0 = tbl[i].ld; PCSrcE = tbl[i].br;
            RdM = tbl[i].rdm; RegWriteM = tbl[i].wm; RdW = tbl[i].rdw; RegWriteW = tbl[i].ww;
            #1;
            chk($sformatf("tbl%0d.FwdA", i), ForwardAE, tbl[i].fa);
            chk($sformatf("tbl%0d.FwdB", i), ForwardBE, tbl[i].fb);
            chk($sformatf("tbl%0d.StallF", i), StallF, tbl[i].sfd);
            chk($sformatf("tbl%0d.StallD", i), StallD, tbl[i].sfd);
            chk($sformatf("tbl%0d.FlushD", i), FlushD, tbl[i].fd);
            chk($sformatf("tbl%0d.FlushE", i), FlushE, tbl[i].fe);
            step($sformatf("tbl%0d", i));
            idle();
            step("tbl_gap");
        end

        // Memory wait: 3 not-ready cycles then ready; a branch pending in E must not flush.
        idle();
        PCSrcE = 1; dmem_req_M = 1; dmem_ready = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready = 1;
            #1;
            if (StallF && StallD && StallE && StallM && StallW && !FlushD && !FlushE) n++;
            step("memwait");
        end
        chk("memwait.frozen_cycles", n, 4);
        dmem_req_M = 0;
        #1;
        chk("memwait.release_stallE", StallE, 0);
        chk("memwait.deferred_flushD", FlushD, 1);
        step("memwait_after");
        idle();
        step("memwait_idle");

        // Timeout: ready held low; error only after the TO-th wait cycle.
        dmem_req_M = 1; dmem_ready = 0;
        for (int i = 0; i < TO + 1; i++) begin
            #1;
            chk("timeout.not_yet", mem_timeout, 0);
            step("timeout");
        end
        #1;
        chk("timeout.set", mem_timeout, 1);
        dmem_ready = 1; PCSrcE = 1;
        for (int i = 0; i < 3; i++) step("timeout_frozen");
        #2 rst_n = 0;
        #1;
        chk("timeout.rst_clear", mem_timeout, 0);
        step("timeout_rst");
        rst_n = 1; idle();
        step("timeout_run");

        // Async reset in the middle of a memory wait, between clock edges.
        ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
        step("pre_wait");
        dmem_req_M = 1; dmem_ready = 0;
        step("wait_a");
        step("wait_b");
        #3 rst_n = 0;
        #1;
        chk("midwait_rst.FlushD", FlushD, 1);
        chk("midwait_rst.FlushE", FlushE, 1);
        chk("midwait_rst.StallE", StallE, 0);
        chk("midwait_rst.stall_cnt", stall_cnt, 0);
        chk("midwait_rst.flush_cnt", flush_cnt, 0);
        step("midwait_rst");
        rst_n = 1; idle();
        step("midwait_after");

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
            RdE = 5'($urandom_range(0, 7)); RdM = 5'($urandom_range(0, 7));
            RdW = 5'($urandom_range(0, 7));
            ResultSrcE0 = 1'($urandom_range(0, 1)); PCSrcE = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            dmem_req_M = ($urandom_range(0, 3) == 0); dmem_ready = ($urandom_range(0, 2) != 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer side of the decode/execute pipeline register.
- Reads the source/destination register indices carried into E, M and W, and the decode-stage sources.
- Drives forwarding selects for the E-stage ALU operands, and stall/flush controls for the F/D/E/M/W pipeline registers.
- Adds a data-memory wait FSM that freezes the whole pipeline while a memory-stage access is not ready, with a timeout error.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before ERROR (≥1).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- Rs1D  in  5  rs1 index in decode
- Rs2D  in  5  rs2 index in decode
- Rs1E  in  5  rs1 index in execute
- Rs2E  in  5  rs2 index in execute
- RdE  in  5  destination in execute
- ResultSrcE0  in  1  E-stage instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- RdM  in  5  destination in memory stage
- RegWriteM  in  1  M-stage writes register file
- RdW  in  5  destination in writeback
- RegWriteW  in  1  W-stage writes register file
- dmem_req_M  in  1  M-stage data-memory access valid
- dmem_ready  in  1  data memory completes access this cycle
- ForwardAE  out  2  operand A select: 00 RD1E, 10 ALUResultM, 01 ResultW
- ForwardBE  out  2  operand B select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- StallE  out  1  hold ID/EX
- StallM  out  1  hold EX/MEM
- StallW  out  1  hold MEM/WB
- FlushD  out  1  clear IF/ID
- FlushE  out  1  clear ID/EX
- mem_timeout  out  1  sticky error
- stall_cnt  out  CNT_W  load-use + memory stall cycles
- flush_cnt  out  CNT_W  branch flush events

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00.
  - ForwardBE is identical with Rs2E.
  - M has priority over W. x0 is never forwarded.
- lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall = (state==MEM_WAIT) || (state==RUN && dmem_req_M && !dmem_ready) || state==ERROR.
- RUN, memStall=0:
  - StallF = StallD = lwStall && !PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = lwStall || PCSrcE.
  - StallE, StallM, StallW = 0.
- memStall=1:
  - StallF, StallD, StallE, StallM, StallW all = 1.
  - FlushD = FlushE = 0 (branch redirect deferred; PCSrcE stays stable because E is frozen).
- FSM states RUN, MEM_WAIT, ERROR, with waitcnt of width $clog2(MEM_TIMEOUT+1):
  - RUN→MEM_WAIT when dmem_req_M && !dmem_ready; waitcnt<=1.
  - MEM_WAIT→RUN when dmem_ready; waitcnt<=0. The release cycle is a MEM_WAIT cycle, so stall is still 1 that cycle.
  - MEM_WAIT, !dmem_ready: waitcnt++. When waitcnt==MEM_TIMEOUT→ERROR, mem_timeout<=1.
  - ERROR: absorbing until reset. Pipeline frozen, no flushes.
- Counters:
  - stall_cnt += 1 each cycle (lwStall&&!PCSrcE) || memStall, excluding ERROR.
  - flush_cnt += 1 each cycle FlushD is asserted.
  - Both wrap modulo 2^CNT_W.
- Reset (rst_n low, async):
  - state=RUN, waitcnt=0, mem_timeout=0, counters=0.
  - While asserted: FlushD=FlushE=1, all Stall*=0, Forward*=00. This inserts bubbles into pipeline registers that have no reset of their own.
  - Reset mid-MEM_WAIT aborts the wait immediately.
- lwStall and PCSrcE together: PCSrcE wins; no F/D stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt/flush_cnt implemented as above.
- Undefined: counter registers are not instantiated; stall_cnt and flush_cnt are tied to 0. Ports remain present.

Decomposition:
- Package hazard_pkg:
  - typedef fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - typedef mem_state_t enum {RUN, MEM_WAIT, ERROR}.
  - constant REG_X0=5'd0.
- One sub-module forward_sel: pure combinational select for one operand, instantiated twice (A and B).

Test Plan:
- Forward priority: RegWriteM=1, RdM=5; RegWriteW=1, RdW=5; Rs1E=5 -> ForwardAE=10. Drop RegWriteM -> 01. Set RdM=RdW=0, Rs1E=0 -> 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly that cycle, stall_cnt +1. RdE=0 -> no stall.
- Branch: PCSrcE=1 with lwStall true -> FlushD=FlushE=1, StallF=StallD=0, flush_cnt +1.
- Memory wait: dmem_req_M=1, dmem_ready=0 for 3 cycles, then 1 -> all Stall*=1 for 4 cycles, FlushD/FlushE=0 throughout, state back to RUN.
- Timeout, MEM_TIMEOUT=4: ready held low -> mem_timeout=1 after the 4th MEM_WAIT cycle; pipeline stays frozen; pulse rst_n -> mem_timeout=0, state RUN.
- Async reset mid-MEM_WAIT, asserted between clock edges -> FlushD=FlushE=1 and Stall*=0 immediately; counters 0. Without HAZARD_PERF_CNT_EN, counters read 0 throughout all tests.
